// File: rtl/cen_controller_if.sv
// Bus between the centering controller, the sample RAM, the centering subtractor
// and the whitening-stage result buffer. The controller connects as master.
interface cen_controller_if #(
    parameter int unsigned DATA_W = 26,
    parameter int unsigned ADDR_W = 10
);
    logic              GO;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [DATA_W-1:0] x1_in;
    logic [DATA_W-1:0] x2_in;
    logic [DATA_W-1:0] x3_in;
    logic [DATA_W-1:0] x4_in;
    logic [DATA_W-1:0] res1;
    logic [DATA_W-1:0] res2;
    logic [DATA_W-1:0] res3;
    logic [DATA_W-1:0] res4;
    logic              sub_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic              busy;
    logic              done;

    modport master (
        input  GO, x1_in, x2_in, x3_in, x4_in,
        output rd_addr, rd_en, res1, res2, res3, res4, sub_en, wr_addr, wr_en, busy, done
    );

    modport slave (
        output GO, x1_in, x2_in, x3_in, x4_in,
        input  rd_addr, rd_en, res1, res2, res3, res4, sub_en, wr_addr, wr_en, busy, done
    );
endinterface

// File: rtl/cen_controller.sv
// Centering-stage sequencer: pass 1 averages N 4-channel samples, pass 2 replays them
// through the subtractor. Define CEN_ROUND_EN for a round-half-up, saturating mean.
module cen_controller #(
    parameter int unsigned DATA_W = 26,
    parameter int unsigned LOG2_N = 10,
    parameter int unsigned ADDR_W = LOG2_N
) (
    input  logic              clk,
    input  logic              rst_n,
    cen_controller_if.master  bus
);
    localparam int unsigned ACC_W = DATA_W + LOG2_N;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'((2 ** LOG2_N) - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAcc,
        StAccDrain,
        StMean,
        StSub,
        StSubDrain,
        StFin
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_en_q, rd_en_d;
    logic              rd_v_q, rd_v_d;
    logic              sub_en_q, sub_en_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_p_q, addr_p_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              drain_q, drain_d;
    logic [ACC_W-1:0]  acc_q [4];
    logic [ACC_W-1:0]  acc_d [4];
    logic [DATA_W-1:0] res_q [4];
    logic [DATA_W-1:0] res_d [4];
    logic [DATA_W-1:0] x_in  [4];

    assign x_in[0] = bus.x1_in;
    assign x_in[1] = bus.x2_in;
    assign x_in[2] = bus.x3_in;
    assign x_in[3] = bus.x4_in;

    function automatic logic [DATA_W-1:0] mean_of(input logic [ACC_W-1:0] acc);
`ifdef CEN_ROUND_EN
        logic [ACC_W:0]        sum;
        logic [ACC_W-LOG2_N:0] quo;
        sum = {1'b0, acc} + ((ACC_W + 1)'(1) << (LOG2_N - 1));
        quo = sum[ACC_W:LOG2_N];
        mean_of = quo[DATA_W] ? {DATA_W{1'b1}} : quo[DATA_W-1:0];
`else
        mean_of = acc[ACC_W-1:LOG2_N];
`endif
    endfunction

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_en_d   = rd_en_q;
        drain_d   = drain_q;
        rd_v_d    = rd_en_q;
        sub_en_d  = (state_q == StSub) && rd_en_q;
        wr_en_d   = sub_en_q;
        addr_p_d  = addr_q;
        wr_addr_d = addr_p_q;
        for (int k = 0; k < 4; k++) begin
            acc_d[k] = acc_q[k];
            res_d[k] = res_q[k];
        end

        // Read data lags rd_en by one cycle, so the last sample lands in ACC_DRAIN.
        if (rd_v_q && (state_q == StAcc || state_q == StAccDrain)) begin
            for (int k = 0; k < 4; k++) begin
                acc_d[k] = acc_q[k] + ACC_W'(x_in[k]);
            end
        end

        case (state_q)
            StIdle: begin
                if (bus.GO) begin
                    for (int k = 0; k < 4; k++) begin
                        acc_d[k] = '0;
                    end
                    addr_d  = '0;
                    rd_en_d = 1'b1;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (addr_q == LastAddr) begin
                    rd_en_d = 1'b0;
                    state_d = StAccDrain;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            StAccDrain: begin
                state_d = StMean;
            end
            StMean: begin
                for (int k = 0; k < 4; k++) begin
                    res_d[k] = mean_of(acc_q[k]);
                end
                addr_d  = '0;
                rd_en_d = 1'b1;
                state_d = StSub;
            end
            StSub: begin
                // One idle SUB cycle after the last read lets sub_en flush before draining.
                if (rd_en_q) begin
                    if (addr_q == LastAddr) begin
                        rd_en_d = 1'b0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end else begin
                    drain_d = 1'b0;
                    state_d = StSubDrain;
                end
            end
            StSubDrain: begin
                if (drain_q) begin
                    state_d = StFin;
                end else begin
                    drain_d = 1'b1;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_v_q    <= 1'b0;
            sub_en_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_p_q  <= '0;
            wr_addr_q <= '0;
            drain_q   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                acc_q[k] <= '0;
                res_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rd_en_q   <= rd_en_d;
            rd_v_q    <= rd_v_d;
            sub_en_q  <= sub_en_d;
            wr_en_q   <= wr_en_d;
            addr_p_q  <= addr_p_d;
            wr_addr_q <= wr_addr_d;
            drain_q   <= drain_d;
            for (int k = 0; k < 4; k++) begin
                acc_q[k] <= acc_d[k];
                res_q[k] <= res_d[k];
            end
        end
    end

    assign bus.rd_addr = addr_q;
    assign bus.rd_en   = rd_en_q;
    assign bus.res1    = res_q[0];
    assign bus.res2    = res_q[1];
    assign bus.res3    = res_q[2];
    assign bus.res4    = res_q[3];
    assign bus.sub_en  = sub_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = (state_q == StFin);
endmodule

// File: tb/tb_cen_controller.sv
// Randomised bench for cen_controller: a small (N=4) and a full-size (N=1024) instance
// run against memory models and a sum/shift reference mean.
module tb_cen_controller;
    localparam int unsigned DW   = 26;
    localparam int unsigned LG_S = 2;
    localparam int unsigned N_S  = 4;
    localparam int unsigned LG_L = 10;
    localparam int unsigned N_L  = 1024;
    localparam longint      MAXV = (64'd1 << DW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    cen_controller_if #(.DATA_W(DW), .ADDR_W(LG_S)) bs ();
    cen_controller_if #(.DATA_W(DW), .ADDR_W(LG_L)) bl ();

    cen_controller #(.DATA_W(DW), .LOG2_N(LG_S), .ADDR_W(LG_S)) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bs.master)
    );

    cen_controller #(.DATA_W(DW), .LOG2_N(LG_L), .ADDR_W(LG_L)) u_large (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bl.master)
    );

    logic [DW-1:0]   mem_s [4][N_S];
    logic [DW-1:0]   mem_l [4][N_L];
    logic [LG_S-1:0] xa_s;

    // Sample RAMs: one-cycle read latency; xa_s tags which address the data came from.
    always @(posedge clk) begin
        if (bs.rd_en) begin
            bs.x1_in <= mem_s[0][bs.rd_addr];
            bs.x2_in <= mem_s[1][bs.rd_addr];
            bs.x3_in <= mem_s[2][bs.rd_addr];
            bs.x4_in <= mem_s[3][bs.rd_addr];
            xa_s     <= bs.rd_addr;
        end
        if (bl.rd_en) begin
            bl.x1_in <= mem_l[0][bl.rd_addr];
            bl.x2_in <= mem_l[1][bl.rd_addr];
            bl.x3_in <= mem_l[2][bl.rd_addr];
            bl.x4_in <= mem_l[3][bl.rd_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint ref_mean(input longint sum, input int lg);
        longint r;
`ifdef CEN_ROUND_EN
        r = (sum + (64'd1 << (lg - 1))) >> lg;
        if (r > MAXV) r = MAXV;
`else
        r = sum >> lg;
`endif
        return r;
    endfunction

    // GO is issued now; g0..g2 re-pulse GO in those cycles, rst_at pulses reset (-1 = none).
    task automatic run_small(input string tag, input int g0, input int g1, input int g2,
                             input int rst_at);
        longint exp_res [4];
        int done_cyc = -1;
        int ndone = 0;
        int nsub = 0;
        int nwr = 0;
        for (int c = 0; c < 4; c++) begin
            longint s = 0;
            for (int a = 0; a < N_S; a++) s += longint'(mem_s[c][a]);
            exp_res[c] = ref_mean(s, LG_S);
        end
        bs.GO = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk);
            #1;
            if (bs.sub_en) begin
                check_eq({tag, ":sub_addr"}, 64'(xa_s), 64'(nsub));
                check_eq({tag, ":sub_x1"}, 64'(bs.x1_in), 64'(mem_s[0][nsub % N_S]));
                nsub++;
            end
            if (bs.wr_en) begin
                check_eq({tag, ":wr_addr"}, 64'(bs.wr_addr), 64'(nwr));
                nwr++;
            end
            if (done_cyc >= 0) begin
                check_eq({tag, ":busy_after_done"}, 64'(bs.busy), 64'd0);
                bs.GO = 1'b0;
                break;
            end
            if (bs.done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (rst_at >= 0 && cyc == rst_at + 1) begin
                check_eq({tag, ":rst_ctl"}, 64'({bs.rd_en, bs.sub_en, bs.wr_en, bs.busy,
                         bs.done, bs.rd_addr, bs.wr_addr}), 64'd0);
                check_eq({tag, ":rst_res"}, 64'(bs.res1 | bs.res2 | bs.res3 | bs.res4), 64'd0);
                rst_n = 1'b1;
            end
            if (rst_at >= 0 && cyc == rst_at) rst_n = 1'b0;
            if (rst_at >= 0 && cyc == rst_at + 20) break;
            bs.GO = (cyc == g0) || (cyc == g1) || (cyc == g2);
        end
        bs.GO = 1'b0;
        if (rst_at >= 0) begin
            check_eq({tag, ":no_done"}, 64'(ndone), 64'd0);
            check_eq({tag, ":idle"}, 64'(bs.busy), 64'd0);
        end else begin
            check_eq({tag, ":done_cycle"}, 64'(done_cyc), 64'(2 * N_S + 6));
            check_eq({tag, ":done_count"}, 64'(ndone), 64'd1);
            check_eq({tag, ":sub_count"}, 64'(nsub), 64'(N_S));
            check_eq({tag, ":wr_count"}, 64'(nwr), 64'(N_S));
            check_eq({tag, ":res1"}, 64'(bs.res1), 64'(exp_res[0]));
            check_eq({tag, ":res2"}, 64'(bs.res2), 64'(exp_res[1]));
            check_eq({tag, ":res3"}, 64'(bs.res3), 64'(exp_res[2]));
            check_eq({tag, ":res4"}, 64'(bs.res4), 64'(exp_res[3]));
        end
    endtask

    task automatic run_large(input string tag);
        longint exp_res [4];
        int done_cyc = -1;
        int nwr = 0;
        int bad_addr = 0;
        for (int c = 0; c < 4; c++) begin
            longint s = 0;
            for (int a = 0; a < N_L; a++) s += longint'(mem_l[c][a]);
            exp_res[c] = ref_mean(s, LG_L);
        end
        bl.GO = 1'b1;
        for (int cyc = 1; cyc <= 2 * N_L + 40; cyc++) begin
            @(posedge clk);
            #1;
            bl.GO = 1'b0;
            if (bl.wr_en) begin
                if (int'(bl.wr_addr) != nwr) bad_addr++;
                nwr++;
            end
            if (bl.done) begin
                done_cyc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        check_eq({tag, ":done_cycle"}, 64'(done_cyc), 64'(2 * N_L + 6));
        check_eq({tag, ":wr_count"}, 64'(nwr), 64'(N_L));
        check_eq({tag, ":wr_addr_errs"}, 64'(bad_addr), 64'd0);
        check_eq({tag, ":res1"}, 64'(bl.res1), 64'(exp_res[0]));
        check_eq({tag, ":res2"}, 64'(bl.res2), 64'(exp_res[1]));
        check_eq({tag, ":res3"}, 64'(bl.res3), 64'(exp_res[2]));
        check_eq({tag, ":res4"}, 64'(bl.res4), 64'(exp_res[3]));
    endtask

    initial begin
        logic [DW-1:0] ramp [4];
        int ramp_exp;
        ramp[0] = 26'd1;
        ramp[1] = 26'd2;
        ramp[2] = 26'd3;
        ramp[3] = 26'd5;
`ifdef CEN_ROUND_EN
        ramp_exp = 3;
`else
        ramp_exp = 2;
`endif
        // Reset with GO held high: reset must win.
        rst_n = 1'b0;
        bs.GO = 1'b1;
        bl.GO = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset:busy_s", 64'(bs.busy), 64'd0);
        check_eq("reset:outs_s", 64'({bs.rd_en, bs.sub_en, bs.wr_en, bs.done, bs.rd_addr,
                 bs.wr_addr}), 64'd0);
        check_eq("reset:res_s", 64'(bs.res1 | bs.res2 | bs.res3 | bs.res4), 64'd0);
        check_eq("reset:busy_l", 64'(bl.busy), 64'd0);
        bs.GO = 1'b0;
        bl.GO = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("reset:still_idle", 64'(bs.busy | bl.busy), 64'd0);

        // Full scale, N=1024: no accumulator overflow.
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < N_L; a++) mem_l[c][a] = DW'(MAXV);
        run_large("full_scale");
        check_eq("full_scale:res_max", 64'(bl.res1), MAXV);
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < N_L; a++) mem_l[c][a] = DW'($urandom);
        run_large("large_rand");

        // Constant 100 on every channel.
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < N_S; a++) mem_s[c][a] = 26'd100;
        run_small("const", -1, -1, -1, -1);
        check_eq("const:res_100", 64'(bs.res4), 64'd100);

        // Ramp on channel 1, random on the others.
        for (int a = 0; a < N_S; a++) begin
            mem_s[0][a] = ramp[a];
            for (int c = 1; c < 4; c++) mem_s[c][a] = DW'($urandom);
        end
        run_small("ramp", -1, -1, -1, -1);
        check_eq("ramp:res1", 64'(bs.res1), 64'(ramp_exp));

        // GO during ACC, during SUB and coincident with FIN: all ignored.
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < N_S; a++) mem_s[c][a] = DW'($urandom);
        run_small("go_busy", 3, N_S + 5, 2 * N_S + 6, -1);

        // Reset mid-SUB, then a clean pass on new data.
        run_small("rst_mid", -1, -1, -1, N_S + 4);
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < N_S; a++) mem_s[c][a] = DW'($urandom_range(0, 1000));
        run_small("after_rst", -1, -1, -1, -1);

        // Back-to-back passes: each GO lands on the first IDLE cycle after done.
        for (int it = 0; it < 4; it++) begin
            for (int c = 0; c < 4; c++)
                for (int a = 0; a < N_S; a++)
                    mem_s[c][a] = (it == 3) ? DW'(MAXV - a) : DW'($urandom);
            run_small("b2b", -1, -1, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
